// File: rtl/cpu_debug_jtag_host.sv
// ---------------------------------------------------------------------------
// cpu_debug_jtag_host
//
// Host-side initiator for the CPU debug slave's virtual-JTAG port. A command
// (IR value + DR_WIDTH-bit word) is expanded into the sequence
// UIR -> CDR -> SHIFT (DR_WIDTH bits) -> UDR -> RTI, and the word captured
// from vji_tdo during SHIFT is returned on rsp_data with a one-clk rsp_valid.
// TCK is generated from clk: each tck half-period lasts TCK_DIV clk cycles.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_ir, cmd_data  virtual IR value and word to shift (bit 0 first)
//   rsp_valid         one-clk pulse when rsp_data is updated
//   rsp_data          captured TDO word (first captured bit in bit 0)
//   vji_tck/tdi/tdo   generated TCK and serial data to/from the slave
//   vji_ir_in         virtual IR, held from accept to the next accept
//   vji_uir/cdr/sdr/udr/rti  one-hot virtual-JTAG state strobes
// ---------------------------------------------------------------------------
module cpu_debug_jtag_host #(
    parameter int DR_WIDTH   = 38,
    parameter int IR_WIDTH   = 2,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int DIV_W   = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int CNT_MAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
    localparam logic [CNT_W-1:0] DR_LAST  = CNT_W'(DR_WIDTH);
    localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'(RTI_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SHIFT,
        S_UDR,
        S_RTI
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tck_q, tck_d;
    logic                tdi_q, tdi_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                uir_q, uir_d;
    logic                cdr_q, cdr_d;
    logic                sdr_q, sdr_d;
    logic                udr_q, udr_d;
    logic                rti_q, rti_d;
    logic                rdy_q, rdy_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [DR_WIDTH-1:0] sh_q, sh_d;

    logic tick;
    logic rise;
    logic fall;
    logic accept;

    // A tick is the clk edge on which tck toggles; its direction is known
    // from the current tck level, so rise/fall are decoded one edge early.
    always_comb begin
        tick   = (state_q != S_IDLE) && (div_q == DIV_LAST);
        rise   = tick && !tck_q;
        fall   = tick && tck_q;
        accept = cmd_valid && rdy_q;
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        tck_d       = tck_q;
        tdi_d       = tdi_q;
        ir_d        = ir_q;
        uir_d       = uir_q;
        cdr_d       = cdr_q;
        sdr_d       = sdr_q;
        udr_d       = udr_q;
        rti_d       = rti_q;
        rdy_d       = rdy_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        sh_d        = sh_q;

        // TCK divider: parked low while idle, free-running otherwise.
        if (state_q == S_IDLE) begin
            div_d = '0;
            tck_d = 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
            tck_d = !tck_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sh_d    = cmd_data;
                    ir_d    = cmd_ir;
                    rti_d   = 1'b0;
                    uir_d   = 1'b1;
                    rdy_d   = 1'b0;
                    state_d = S_UIR;
                end
            end
            S_UIR: begin
                if (fall) begin
                    uir_d   = 1'b0;
                    cdr_d   = 1'b1;
                    state_d = S_CDR;
                end
            end
            S_CDR: begin
                if (fall) begin
                    cdr_d   = 1'b0;
                    sdr_d   = 1'b1;
                    tdi_d   = sh_q[0];
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // The slave samples tdi on the rise, so tdo is captured on
                // the same edge and tdi only advances on the following fall.
                if (rise) begin
                    sh_d  = {vji_tdo, sh_q[DR_WIDTH-1:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (fall) begin
                    if (cnt_q == DR_LAST) begin
                        sdr_d   = 1'b0;
                        udr_d   = 1'b1;
                        tdi_d   = 1'b0;
                        state_d = S_UDR;
                    end else begin
                        tdi_d = sh_q[0];
                    end
                end
            end
            S_UDR: begin
                if (fall) begin
                    udr_d       = 1'b0;
                    rti_d       = 1'b1;
                    rsp_data_d  = sh_q;
                    rsp_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_RTI;
                end
            end
            S_RTI: begin
                // Counter tracks completed rises, so the period count is
                // reached on the fall that closes the last RTI period.
                if (rise) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (fall && (cnt_q == RTI_LAST)) begin
                    rdy_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            ir_q        <= '0;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
            rti_q       <= 1'b1;
            rdy_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            tck_q       <= tck_d;
            tdi_q       <= tdi_d;
            ir_q        <= ir_d;
            uir_q       <= uir_d;
            cdr_q       <= cdr_d;
            sdr_q       <= sdr_d;
            udr_q       <= udr_d;
            rti_q       <= rti_d;
            rdy_q       <= rdy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Shift register is always loaded on accept before use, so it needs no reset.
    always_ff @(posedge clk) begin
        sh_q <= sh_d;
    end

    assign cmd_ready = rdy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign vji_tck   = tck_q;
    assign vji_tdi   = tdi_q;
    assign vji_ir_in = ir_q;
    assign vji_uir   = uir_q;
    assign vji_cdr   = cdr_q;
    assign vji_sdr   = sdr_q;
    assign vji_udr   = udr_q;
    assign vji_rti   = rti_q;

endmodule

// File: tb/tb_cpu_debug_jtag_host.sv
// ---------------------------------------------------------------------------
// tb_cpu_debug_jtag_host
//
// Three instances share clk/reset_n:
//   gi[0]  defaults (TCK_DIV=2, RTI_CYCLES=2)
//   gi[1]  TCK_DIV=1
//   gi[2]  TCK_DIV=3, RTI_CYCLES=1
// Each instance has a DR_WIDTH-bit slave shift register (cleared by reset)
// on its vji pins, and a negedge monitor acting as scoreboard.
// ---------------------------------------------------------------------------
module tb_cpu_debug_jtag_host;

    localparam int DRW = 38;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic           cmd_valid [3];
    logic           cmd_ready [3];
    logic [1:0]     cmd_ir    [3];
    logic [DRW-1:0] cmd_data  [3];
    logic           rsp_valid [3];
    logic [DRW-1:0] rsp_data  [3];
    logic           tck       [3];
    logic           tdi       [3];
    logic           tdo       [3];
    logic [1:0]     ir_in     [3];
    logic           uir       [3];
    logic           cdr       [3];
    logic           sdr       [3];
    logic           udr       [3];
    logic           rti       [3];
    bit             cont      [3];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    always #5 clk = !clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int TD  = (g == 1) ? 1 : ((g == 2) ? 3 : 2);
        localparam int RC  = (g == 2) ? 1 : 2;
        localparam int LAT = (3 + DRW) * 2 * TD;
        localparam int RDY = (3 + DRW + RC) * 2 * TD;

        logic [DRW-1:0] slv_sr;
        int             sdr_rises;

        cpu_debug_jtag_host #(
            .DR_WIDTH  (DRW),
            .IR_WIDTH  (2),
            .TCK_DIV   (TD),
            .RTI_CYCLES(RC)
        ) dut (
            .clk      (clk),
            .reset_n  (reset_n),
            .cmd_valid(cmd_valid[g]),
            .cmd_ready(cmd_ready[g]),
            .cmd_ir   (cmd_ir[g]),
            .cmd_data (cmd_data[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_data (rsp_data[g]),
            .vji_tck  (tck[g]),
            .vji_tdi  (tdi[g]),
            .vji_tdo  (tdo[g]),
            .vji_ir_in(ir_in[g]),
            .vji_uir  (uir[g]),
            .vji_cdr  (cdr[g]),
            .vji_sdr  (sdr[g]),
            .vji_udr  (udr[g]),
            .vji_rti  (rti[g])
        );

        // Slave data register: shifts on every tck rise while in shift-DR.
        assign tdo[g] = slv_sr[0];

        always @(posedge tck[g] or negedge reset_n) begin
            if (!reset_n) begin
                slv_sr    <= '0;
                sdr_rises <= 0;
            end else if (sdr[g]) begin
                slv_sr    <= {tdi[g], slv_sr[DRW-1:1]};
                sdr_rises <= sdr_rises + 1;
            end
        end

        logic [DRW-1:0] exp_q [$];
        int             acc_q [$];
        logic [DRW-1:0] model_sr;
        logic [DRW-1:0] cur_data;
        logic [DRW-1:0] p_cdata;
        logic [DRW-1:0] p_rdata;
        logic [5:0]     p_str;
        logic [1:0]     p_ir;
        logic [1:0]     p_cir;
        logic           p_valid;
        logic           p_ready;
        logic           p_tck;
        int             acc_cyc;
        int             bit_idx;
        int             len [4];
        bit             have_acc;
        bit             last_cont;

        initial begin : mon
            logic [5:0]     s;
            logic [DRW-1:0] e;
            int             a;
            bit             acc;
            forever begin
                @(negedge clk);
                s = {uir[g], cdr[g], sdr[g], udr[g], rti[g], tdi[g]};
                if (!reset_n) begin
                    exp_q.delete();
                    acc_q.delete();
                    model_sr  = '0;
                    have_acc  = 1'b0;
                    last_cont = 1'b0;
                    bit_idx   = 0;
                    for (int i = 0; i < 4; i++) len[i] = 0;
                end else begin
                    acc = p_valid && p_ready;
                    if (acc) begin
                        chk("acc_ir", ir_in[g], p_cir);
                        chk("acc_strobes", {s[5:1], cmd_ready[g]}, 6'b100000);
                        if (cont[g] && last_cont) chk("acc_spacing", cyc - acc_cyc, RDY + 1);
                        last_cont = cont[g];
                        exp_q.push_back(model_sr);
                        acc_q.push_back(cyc);
                        model_sr = p_cdata;
                        cur_data = p_cdata;
                        bit_idx  = 0;
                        acc_cyc  = cyc;
                        have_acc = 1'b1;
                    end else begin
                        chk("ir_hold", ir_in[g], p_ir);
                    end

                    chk("onehot", $countones(s[5:1]), 1);
                    if (cmd_ready[g]) chk("idle_outputs", {s, tck[g]}, 7'b0000100);

                    if (tck[g] && !p_tck) begin
                        chk("rise_quiet", s, p_str);
                        if (sdr[g]) begin
                            if (bit_idx < DRW) chk("tdi_bit", tdi[g], cur_data[bit_idx]);
                            bit_idx++;
                        end
                    end
                    if (!sdr[g] && p_str[3]) chk("sdr_rises", bit_idx, DRW);

                    for (int i = 0; i < 4; i++) begin
                        if (s[5-i]) begin
                            len[i]++;
                        end else if (p_str[5-i]) begin
                            chk("strobe_len", len[i], (i == 2) ? DRW * 2 * TD : 2 * TD);
                            len[i] = 0;
                        end
                    end

                    if (rsp_valid[g]) begin
                        chk("rsp_pending", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            a = acc_q.pop_front();
                            chk("rsp_data", rsp_data[g], e);
                            chk("rsp_latency", cyc - a, LAT);
                        end
                    end else begin
                        chk("rsp_hold", rsp_data[g], p_rdata);
                    end

                    if (cmd_ready[g] && !p_ready && have_acc) chk("ready_latency", cyc - acc_cyc, RDY);
                end
                p_valid = cmd_valid[g];
                p_ready = cmd_ready[g];
                p_tck   = tck[g];
                p_str   = s;
                p_ir    = ir_in[g];
                p_cir   = cmd_ir[g];
                p_cdata = cmd_data[g];
                p_rdata = rsp_data[g];
            end
        end
    end

    task automatic rst_vals(input int g);
        chk("rst_tck", tck[g], 0);
        chk("rst_tdi", tdi[g], 0);
        chk("rst_ir", ir_in[g], 0);
        chk("rst_strobes", {uir[g], cdr[g], sdr[g], udr[g], rti[g]}, 5'b00001);
        chk("rst_rsp_valid", rsp_valid[g], 0);
        chk("rst_rsp_data", rsp_data[g], 0);
        chk("rst_ready", cmd_ready[g], 1);
    endtask

    task automatic wait_ready(input int g, input bit level);
        int n;
        n = 0;
        while ((cmd_ready[g] !== level) && (n < 2000)) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_wait", cmd_ready[g], level);
    endtask

    // Called at posedge+1; returns at posedge+1 with the instance idle again.
    task automatic send(input int g, input logic [1:0] ir, input logic [DRW-1:0] d);
        wait_ready(g, 1'b1);
        cmd_ir[g]    = ir;
        cmd_data[g]  = d;
        cmd_valid[g] = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid[g] = 1'b0;
        wait_ready(g, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DRW-1:0] dseq [4];
        logic [1:0]     ir;
        int             base;
        int             n;

        for (int g = 0; g < 3; g++) begin
            cmd_valid[g] = 1'b0;
            cmd_ir[g]    = '0;
            cmd_data[g]  = '0;
            cont[g]      = 1'b0;
        end

        // Reset, then 20 idle clocks
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) rst_vals(g);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) rst_vals(g);

        // Loopback through the slave register (preloaded 0)
        send(0, 2'b01, 38'h2A_5A5A_5A5A);
        chk("loop_first", rsp_data[0], 0);
        send(0, 2'b01, '0);
        chk("loop_second", rsp_data[0], 38'h2A_5A5A_5A5A);

        // Strobe timing with TCK_DIV=1
        send(1, 2'b00, 38'h3F_FFFF_FFFF);
        send(1, 2'b10, 38'h00_0000_0001);
        chk("div1_rsp", rsp_data[1], 38'h3F_FFFF_FFFF);

        // Reset on the 10th shift rise
        base = gi[0].sdr_rises;
        cmd_ir[0]    = 2'b11;
        cmd_data[0]  = 38'h15_0F0F_1234;
        cmd_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid[0] = 1'b0;
        n = 0;
        while ((gi[0].sdr_rises < base + 10) && (n < 2000)) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_reach", gi[0].sdr_rises, base + 10);
        reset_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) rst_vals(g);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send(0, 2'b10, 38'h0C_3C3C_C3C3);
        chk("post_abort_rsp", rsp_data[0], 0);

        // cmd_valid held high, IR alternating
        dseq[0] = 38'h01_2345_6789;
        dseq[1] = 38'h3F_FFFF_FFFF;
        dseq[2] = 38'h20_0000_0001;
        dseq[3] = 38'h1A_BCDE_F012;
        ir = 2'b10;
        cont[0]      = 1'b1;
        cmd_ir[0]    = ir;
        cmd_data[0]  = dseq[0];
        cmd_valid[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ready(0, 1'b0);
            if (k == 3) begin
                cmd_valid[0] = 1'b0;
            end else begin
                ir          = (ir == 2'b10) ? 2'b11 : 2'b10;
                cmd_ir[0]   = ir;
                cmd_data[0] = dseq[k+1];
                wait_ready(0, 1'b1);
            end
        end
        wait_ready(0, 1'b1);
        cont[0] = 1'b0;
        chk("cont_last_rsp", rsp_data[0], dseq[2]);

        // TCK_DIV=3, RTI_CYCLES=1
        send(2, 2'b01, 38'h2B_DEAD_BEEF);
        send(2, 2'b10, 38'h11_1111_1111);
        chk("div3_rsp", rsp_data[2], 38'h2B_DEAD_BEEF);

        repeat (4) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_debug_jtag_host.md
Name: cpu_debug_jtag_host

Overview:
Host-side initiator for the CPU debug slave's virtual-JTAG interface. It turns a command (IR value plus DR_WIDTH-bit data word) into the full virtual-JTAG sequence, then returns the captured TDO word. The sequence is UIR, CDR, SHIFT of DR_WIDTH bits, UDR, and finally run-test-idle. It sits on the system clock and drives the tck/tdi/ir_in/state strobes that the debug slave's TCK side consumes. It is used by on-chip self-test and by simulation benches.

Parameters:
DR_WIDTH, 38, data-register length in bits.
IR_WIDTH, 2, virtual IR width.
TCK_DIV, 2, clk cycles per tck half-period; legal range is 1 or more.
RTI_CYCLES, 2, tck periods spent in run-test-idle after UDR; legal range is 1 or more.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  high only in IDLE.
cmd_ir  in  IR_WIDTH  IR value for this command.
cmd_data  in  DR_WIDTH  word to shift in, bit 0 first.
rsp_valid  out  1  one-clk pulse, captured word valid.
rsp_data  out  DR_WIDTH  captured TDO word, first-captured bit in bit 0.
vji_tck  out  1  generated TCK.
vji_tdi  out  1  serial data to slave.
vji_tdo  in  1  serial data from slave.
vji_ir_in  out  IR_WIDTH  virtual IR.
vji_uir  out  1  update-IR state.
vji_cdr  out  1  capture-DR state.
vji_sdr  out  1  shift-DR state.
vji_udr  out  1  update-DR state.
vji_rti  out  1  run-test-idle state.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, tck=0, tdi=0, ir_in=0, uir=cdr=sdr=udr=0, rti=1, rsp_valid=0, rsp_data=0, divider=0, bit counter=0.
- A reset mid-command aborts immediately. No rsp_valid is produced and the command is lost.
- TCK generation:
  - In IDLE the divider is held at 0 and tck=0.
  - Elsewhere the divider counts 0..TCK_DIV-1; at TCK_DIV-1 it wraps and tck toggles.
  - A "rise" is the clk edge where tck goes 0->1; a "fall" is the edge where tck goes 1->0.
  - One tck period equals 2*TCK_DIV clk cycles and starts with tck low.
- Outputs are all registered. State strobes and tdi change only on the accept edge or on a fall; they never change on a rise.
- Accept: cmd_valid&&cmd_ready at a clk edge causes the following on that edge:
  - latch cmd_data into the shift register sh;
  - set ir_in=cmd_ir (held until the next accept);
  - rti=0, uir=1, cmd_ready=0, state=UIR.
- UIR lasts 1 tck period; on its final fall go to CDR (cdr=1).
- CDR lasts 1 tck period; on its final fall go to SHIFT with sdr=1 and tdi=sh[0].
- SHIFT lasts DR_WIDTH tck periods:
  - on each rise, sh <= {vji_tdo, sh[DR_WIDTH-1:1]} and the bit counter increments;
  - on each fall, tdi <= sh[0];
  - on the fall after the DR_WIDTH-th rise, go to UDR (sdr=0, udr=1, tdi=0).
- UDR lasts 1 tck period; on its final fall:
  - udr=0, rsp_data<=sh, rsp_valid=1 for exactly one clk;
  - go to RTI with rti=1.
- RTI lasts RTI_CYCLES tck periods; on its final fall go to IDLE with cmd_ready=1.
- Latency from accept to rsp_valid is (3+DR_WIDTH)*2*TCK_DIV clk. With the defaults this is 41*4=164 clk.
- Accept to cmd_ready high takes (3+DR_WIDTH+RTI_CYCLES)*2*TCK_DIV clk. With the defaults this is 172 clk.
- Exactly one of uir/cdr/sdr/udr/rti is high outside IDLE; in IDLE only rti is high.
- cmd_valid while busy is ignored, not queued. Back-to-back commands are therefore separated by at least one IDLE clk.
- rsp_data holds its value until the next rsp_valid.
- ir_in=0 or any other IR value is legal; the block does not interpret IR or data.

Test Plan:
1. Reset then idle for 20 clk: tck=0, rti=1, cmd_ready=1, all other outputs 0, no rsp_valid.
2. Loopback (tdo tied to tdi, one-tck delay model of a DR_WIDTH register preloaded 0), defaults, cmd_ir=2'b01, cmd_data=38'h2A_5A5A_5A5A:
   - tdi bit sequence equals cmd_data LSB-first;
   - rsp_valid exactly 164 clk after accept with rsp_data=0;
   - a second command with cmd_data=0 returns 38'h2A_5A5A_5A5A.
3. Strobe timing, TCK_DIV=1:
   - uir, cdr and udr each high exactly 2 clk;
   - sdr high exactly 76 clk;
   - rti low from accept until UDR ends;
   - no strobe or tdi edge coincides with a rise.
4. Reset asserted on the 10th rise of SHIFT: all outputs return to reset values immediately; no rsp_valid; a new command then completes normally.
5. cmd_valid held high continuously with alternating cmd_ir 2'b10/2'b11:
   - exactly one accept per cmd_ready pulse;
   - ir_in changes only on accept edges;
   - commands are spaced 172+1 clk.
6. TCK_DIV=3, RTI_CYCLES=1 with a slave model: the slave sees 38 rises with sdr=1, and rsp_data matches the model's captured sr.
